// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: function codes, FSM states and the
// program instruction record.
package alu_seq_pkg;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_MUL = 2'b01;
  localparam logic [1:0] FN_SHL = 2'b10;
  localparam logic [1:0] FN_CAT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] func;
    logic [3:0] data;
  } instr_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Program/control/status bundle between the board wrapper and alu_sequencer.
// SEQ_SINGLE_STEP_EN adds the step input.
interface alu_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [1:0]        prog_func;
  logic [3:0]        prog_data;
  logic [ADDR_W:0]   len;
  logic              start;
`ifdef SEQ_SINGLE_STEP_EN
  logic              step;
`endif
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        acc_out;

  modport master (
    output prog_we, prog_addr, prog_func, prog_data, len, start,
`ifdef SEQ_SINGLE_STEP_EN
    output step,
`endif
    input  busy, done, pc, acc_out
  );

  modport slave (
    input  prog_we, prog_addr, prog_func, prog_data, len, start,
`ifdef SEQ_SINGLE_STEP_EN
    input  step,
`endif
    output busy, done, pc, acc_out
  );

endinterface

// File: rtl/alu_core.sv
// Combinational 4-bit ALU producing an 8-bit result: add, multiply,
// left shift of B by A, and concatenation {A,B}.
module alu_core
  import alu_seq_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] f,
  output logic [7:0] out
);

  logic [7:0] a_ext;
  logic [7:0] b_ext;

  assign a_ext = {4'b0000, A};
  assign b_ext = {4'b0000, B};

  always_comb begin
    out = 8'h00;
    case (f)
      FN_ADD: out = a_ext + b_ext;
      FN_MUL: out = a_ext * b_ext;
      // Shift amounts of 8 or more push every bit out of the byte.
      FN_SHL: out = A[3] ? 8'h00 : (b_ext << A[2:0]);
      FN_CAT: out = {A, B};
      default: out = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Runs a small (func, data) program against an 8-bit accumulator, one
// instruction per clock. Optional macro SEQ_SINGLE_STEP_EN gates RUN with step.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic          Clock,
  input  logic          Reset_b,
  alu_sequencer_if.slave bus
);

  localparam int LEN_W = ADDR_W + 1;

  state_t            state_reg;
  logic [7:0]        acc_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              busy_reg;
  logic              done_reg;

  instr_t            mem [DEPTH];
  instr_t            cur_instr;
  logic [3:0]        alu_a;
  logic [7:0]        alu_out;
  logic [LEN_W-1:0]  len_sat;
  logic              last_instr;
  logic              advance;

  // Program memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge Clock) begin
    if (bus.prog_we && (state_reg == IDLE)) begin
      mem[bus.prog_addr] <= '{func: bus.prog_func, data: bus.prog_data};
    end
  end

  assign cur_instr  = mem[pc_reg];
  assign alu_a      = (cur_instr.func == FN_CAT) ? acc_reg[7:4] : cur_instr.data;
  assign len_sat    = (bus.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len;
  assign last_instr = ({1'b0, pc_reg} == (len_reg - LEN_W'(1)));

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = bus.step;
`else
  assign advance = 1'b1;
`endif

  alu_core u_alu (
    .A   (alu_a),
    .B   (acc_reg[3:0]),
    .f   (cur_instr.func),
    .out (alu_out)
  );

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_reg <= IDLE;
      acc_reg   <= 8'h00;
      pc_reg    <= '0;
      len_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            len_reg  <= len_sat;
            acc_reg  <= 8'h00;
            pc_reg   <= '0;
            busy_reg <= 1'b1;
            if (len_sat == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (advance) begin
            acc_reg <= alu_out;
            if (last_instr) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              pc_reg <= pc_reg + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.pc      = pc_reg;
  assign bus.acc_out = acc_reg;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Programmable sequencer for the 4-bit ALU + 8-bit accumulator datapath used on the lab board. It holds a small program of (Function, Data) instructions, then on start executes it back-to-back against an internal accumulator, one instruction per clock. It replaces manual KEY-clocking of the ALU/register pair. Results go to LEDR/HEX through the board wrapper.

Parameters:
DEPTH, 8, number of program entries.
ADDR_W, 3, program address width; DEPTH equals 2**ADDR_W.

Ports:
Clock  input  1  system clock, rising edge.
Reset_b  input  1  asynchronous, active-low reset.
prog_we  input  1  program write strobe, sampled on rising Clock.
prog_addr  input  ADDR_W  program write address.
prog_func  input  2  instruction function code: 00 add, 01 mul, 10 shift, 11 concat.
prog_data  input  4  instruction 4-bit operand.
len  input  ADDR_W+1  number of instructions to run, 0..DEPTH; sampled at start.
start  input  1  level; accepted only in IDLE.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when the program completes.
pc  output  ADDR_W  index of the instruction currently executing.
acc_out  output  8  accumulator value.

Behaviour:
- Reset (Reset_b=0, asynchronous): state=IDLE, acc_out=0, pc=0, busy=0, done=0. Program memory is not cleared.
- States and transitions:
  - IDLE, on start=1:
    - latch len into len_q, clear acc to 0, pc=0.
    - if len=0, go to DONE; otherwise go to RUN.
  - RUN, every cycle:
    - acc <= alu(A, acc[3:0], f), where f=mem[pc].func.
    - A=acc[7:4] when f=11; otherwise A=mem[pc].data.
    - if pc==len_q-1, go to DONE; else pc <= pc+1.
  - DONE: done=1 for exactly one cycle, then IDLE. pc holds its last value.
- Timing:
  - Latency: done is high in cycle len+1 after the start cycle.
  - acc_out is final in the same cycle done is high, and holds until the next start or reset.
- ALU arithmetic (all results 8-bit, operands zero-extended):
  - add: result = A+B, maximum 30.
  - mul: result = A*B, maximum 225.
  - shift: result = {4'b0,B}<<A, truncated to 8 bits; A>=8 gives 0.
  - concat: result = {A,B}.
- Program writes:
  - prog_we is honoured only in IDLE; it is ignored while busy.
  - A write and a start in the same IDLE cycle: the write commits, and the run reads the new value.
- start while busy is ignored. len>DEPTH is saturated to DEPTH.
- Reset mid-run aborts immediately: no done pulse, acc_out=0.

Optional Feature:
SEQ_SINGLE_STEP_EN adds an input step (1 bit).
- With the macro: in RUN, an instruction executes and pc advances only in cycles where step=1. Otherwise acc and pc hold. DONE/IDLE behaviour is unchanged.
- Without the macro: there is no step port, and RUN advances every cycle.

Decomposition:
- Shared package (alu_seq_pkg) holds:
  - function-code constants FN_ADD=2'b00, FN_MUL=2'b01, FN_SHL=2'b10, FN_CAT=2'b11.
  - state encoding IDLE/RUN/DONE.
  - instruction record type {func[1:0], data[3:0]}.
- One sub-module: alu_core, purely combinational. Inputs A[3:0], B[3:0], f[1:0]; output out[7:0], with the arithmetic above. The FSM, program memory and accumulator live in alu_sequencer.

Test Plan:
- Program [00,3],[01,5],[10,1],[11,0], len=4, start: acc steps 0x03, 0x0F, 0x1E, 0x1E; done pulses in cycle 5; busy high in cycles 1-5.
- Program [00,F],[01,F], len=2: acc=0x0F, then 0xE1; done in cycle 3.
- Program [00,1],[10,8], len=2: shift by 8 gives acc=0x00. Then program [00,1],[10,7] gives acc=0x80.
- len=0, start: no RUN cycle; done in cycle 1; acc_out=0.
- Start pulsed again and prog_we asserted mid-run: both ignored, memory unchanged; assert Reset_b=0 at cycle 2: acc_out=0, busy=0 immediately, no done.
- With SEQ_SINGLE_STEP_EN, len=2, step asserted only every third cycle: acc changes only on step cycles; done follows the second step.
